// File: rtl/cpu_run_monitor_pkg.sv
// Shared definitions for the CPU run monitor: state encodings, opcode
// constants and the default run limits.
package cpu_run_monitor_pkg;

    // Monitor FSM encodings; values are visible on the state output.
    typedef enum logic [2:0] {
        MON_IDLE    = 3'd0,
        MON_RUN     = 3'd1,
        MON_DONE    = 3'd2,
        MON_TIMEOUT = 3'd3,
        MON_FAULT   = 3'd4
    } mon_state_e;

    // Decoded opcode values produced by cpu_top.
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_LD   = 4'h4;
    localparam logic [3:0] OP_ST   = 4'h5;
    localparam logic [3:0] OP_MAC4 = 4'h8;

    // Default run limits.
    localparam int DEF_END_PC      = 32;
    localparam int DEF_TIMEOUT_CYC = 50;

    // DONE, TIMEOUT and FAULT all stall the CPU.
    function automatic logic is_terminal(mon_state_e s);
        return (s == MON_DONE) || (s == MON_TIMEOUT) || (s == MON_FAULT);
    endfunction

endpackage

// File: rtl/cpu_run_monitor_if.sv
// Bundle of CPU taps into the monitor and the monitor's status back out.
// master = CPU/debug side driving the taps, slave = the monitor.
interface cpu_run_monitor_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic              run_en;
    logic [ADDR_W-1:0] pc_value;
    logic [3:0]        opcode;
    logic [DATA_W-1:0] alu_result;
    logic              parity_error;
    logic [DATA_W-1:0] result_reg;

    logic [2:0]        state;
    logic              done;
    logic              timeout;
    logic              fault;
    logic              halt_req;
    logic [CNT_W-1:0]  cycle_count;
    logic [CNT_W-1:0]  mac_count;
    logic [CNT_W-1:0]  perr_count;
    logic [DATA_W-1:0] last_mac;
    logic [ADDR_W-1:0] first_perr_pc;
    logic [DATA_W-1:0] final_result;

    modport master (
        output run_en, pc_value, opcode, alu_result, parity_error, result_reg,
        input  state, done, timeout, fault, halt_req, cycle_count, mac_count,
               perr_count, last_mac, first_perr_pc, final_result
    );

    modport slave (
        input  run_en, pc_value, opcode, alu_result, parity_error, result_reg,
        output state, done, timeout, fault, halt_req, cycle_count, mac_count,
               perr_count, last_mac, first_perr_pc, final_result
    );
endinterface

// File: rtl/cpu_run_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);
    logic [W-1:0] r_count;

    // Clear wins over increment; increment stops once all bits are set.
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;
endmodule

// File: rtl/cpu_run_monitor.sv
// Run-control monitor beside cpu_top: counts run cycles, MACs and parity
// errors, ends the run on end-PC / watchdog / parity fault, latches the
// final result and requests a CPU halt.
module cpu_run_monitor
    import cpu_run_monitor_pkg::*;
#(
    parameter int                ADDR_W       = 32,
    parameter int                DATA_W       = 32,
    parameter int                CNT_W        = 16,
    parameter logic [ADDR_W-1:0] END_PC       = ADDR_W'(DEF_END_PC),
    parameter int                TIMEOUT_CYC  = DEF_TIMEOUT_CYC,
    parameter logic [3:0]        MAC_OPCODE   = OP_MAC4,
    parameter bit                STOP_ON_PERR = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    cpu_run_monitor_if.slave  bus
);
    // Watchdog fires on the sample whose pre-increment count is TIMEOUT_CYC-1.
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC - 1);

    mon_state_e        r_state;
    mon_state_e        w_state_nxt;
    logic              r_done;
    logic              r_timeout;
    logic              r_fault;
    logic              r_halt;
    logic [DATA_W-1:0] r_last_mac;
    logic [ADDR_W-1:0] r_first_perr_pc;
    logic [DATA_W-1:0] r_final_result;

    logic              w_sample;
    logic              w_is_mac;
    logic              w_is_perr;
    logic              w_end_pc;
    logic              w_to_hit;
    logic [CNT_W-1:0]  w_cyc;
    logic [CNT_W-1:0]  w_mac;
    logic [CNT_W-1:0]  w_perr;

    // Only RUN cycles with run_en high are samples; everything else holds.
    assign w_sample  = (r_state == MON_RUN) && bus.run_en;
    assign w_is_mac  = w_sample && (bus.opcode == MAC_OPCODE);
    assign w_is_perr = w_sample && bus.parity_error;
    assign w_end_pc  = (bus.pc_value >= END_PC);
    assign w_to_hit  = (TIMEOUT_CYC != 0) && (32'(w_cyc) == TO_LAST);

    sat_counter #(.W(CNT_W)) u_cyc_cnt (
        .i_clk   (clk),
        .i_clr   (rst),
        .i_inc   (w_sample),
        .o_count (w_cyc)
    );

    sat_counter #(.W(CNT_W)) u_mac_cnt (
        .i_clk   (clk),
        .i_clr   (rst),
        .i_inc   (w_is_mac),
        .o_count (w_mac)
    );

    sat_counter #(.W(CNT_W)) u_perr_cnt (
        .i_clk   (clk),
        .i_clr   (rst),
        .i_inc   (w_is_perr),
        .o_count (w_perr)
    );

    // Next state: IDLE arms on run_en; a sample may end the run with
    // priority FAULT > DONE > TIMEOUT; terminal states hold until reset.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            MON_IDLE: begin
                if (bus.run_en) begin
                    w_state_nxt = MON_RUN;
                end
            end
            MON_RUN: begin
                if (bus.run_en) begin
                    if (STOP_ON_PERR && bus.parity_error) begin
                        w_state_nxt = MON_FAULT;
                    end else if (w_end_pc) begin
                        w_state_nxt = MON_DONE;
                    end else if (w_to_hit) begin
                        w_state_nxt = MON_TIMEOUT;
                    end
                end
            end
            default: w_state_nxt = r_state;
        endcase
    end

    // State and its registered flag decodes update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= MON_IDLE;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_fault   <= 1'b0;
            r_halt    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_done    <= (w_state_nxt == MON_DONE);
            r_timeout <= (w_state_nxt == MON_TIMEOUT);
            r_fault   <= (w_state_nxt == MON_FAULT);
            r_halt    <= is_terminal(w_state_nxt);
        end
    end

    // Captures: last MAC result, PC of the first parity error, and the
    // result register on the sample that completes the run.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_mac      <= '0;
            r_first_perr_pc <= '0;
            r_final_result  <= '0;
        end else begin
            if (w_is_mac) begin
                r_last_mac <= bus.alu_result;
            end
            if (w_is_perr && (w_perr == '0)) begin
                r_first_perr_pc <= bus.pc_value;
            end
            if (w_sample && (w_state_nxt == MON_DONE)) begin
                r_final_result <= bus.result_reg;
            end
        end
    end

    assign bus.state         = r_state;
    assign bus.done          = r_done;
    assign bus.timeout       = r_timeout;
    assign bus.fault         = r_fault;
    assign bus.halt_req      = r_halt;
    assign bus.cycle_count   = w_cyc;
    assign bus.mac_count     = w_mac;
    assign bus.perr_count    = w_perr;
    assign bus.last_mac      = r_last_mac;
    assign bus.first_perr_pc = r_first_perr_pc;
    assign bus.final_result  = r_final_result;
endmodule

// File: tb/tb_cpu_run_monitor.sv
// Bench for cpu_run_monitor: three configurations share one stimulus
// stream (A: defaults, B: parity counted only, C: 4-bit counters) and are
// checked every cycle against a plain behavioural model.
module tb_cpu_run_monitor;
    import cpu_run_monitor_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        run_en = 1'b0;
    logic [31:0] pc_value = '0;
    logic [3:0]  opcode = '0;
    logic [31:0] alu_result = '0;
    logic        parity_error = 1'b0;
    logic [31:0] result_reg = '0;

    cpu_run_monitor_if #(.ADDR_W(32), .DATA_W(32), .CNT_W(16)) ifA ();
    cpu_run_monitor_if #(.ADDR_W(32), .DATA_W(32), .CNT_W(16)) ifB ();
    cpu_run_monitor_if #(.ADDR_W(32), .DATA_W(32), .CNT_W(4))  ifC ();

    assign ifA.run_en = run_en;  assign ifB.run_en = run_en;  assign ifC.run_en = run_en;
    assign ifA.pc_value = pc_value;  assign ifB.pc_value = pc_value;  assign ifC.pc_value = pc_value;
    assign ifA.opcode = opcode;  assign ifB.opcode = opcode;  assign ifC.opcode = opcode;
    assign ifA.alu_result = alu_result;  assign ifB.alu_result = alu_result;  assign ifC.alu_result = alu_result;
    assign ifA.parity_error = parity_error;  assign ifB.parity_error = parity_error;  assign ifC.parity_error = parity_error;
    assign ifA.result_reg = result_reg;  assign ifB.result_reg = result_reg;  assign ifC.result_reg = result_reg;

    cpu_run_monitor #(.CNT_W(16), .TIMEOUT_CYC(50), .STOP_ON_PERR(1'b1)) uA (.clk(clk), .rst(rst), .bus(ifA.slave));
    cpu_run_monitor #(.CNT_W(16), .TIMEOUT_CYC(50), .STOP_ON_PERR(1'b0)) uB (.clk(clk), .rst(rst), .bus(ifB.slave));
    cpu_run_monitor #(.CNT_W(4),  .TIMEOUT_CYC(50), .STOP_ON_PERR(1'b1)) uC (.clk(clk), .rst(rst), .bus(ifC.slave));

    int n_pass = 0;
    int n_tot  = 0;
    bit chk_en = 1'b0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    endtask

    // Behavioural model: run phase 0=idle 1=run 2=done 3=timeout 4=fault.
    int unsigned m_st[3], m_cyc[3], m_mac[3], m_perr[3];
    logic [31:0] m_lm[3], m_fp[3], m_fr[3];
    int unsigned m_max[3] = '{65535, 65535, 15};
    bit          m_stop[3] = '{1'b1, 1'b0, 1'b1};
    int unsigned m_pre;

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                m_st[k] = 0; m_cyc[k] = 0; m_mac[k] = 0; m_perr[k] = 0;
                m_lm[k] = '0; m_fp[k] = '0; m_fr[k] = '0;
            end else if (m_st[k] == 0) begin
                if (run_en) m_st[k] = 1;
            end else if (m_st[k] == 1 && run_en) begin
                m_pre = m_cyc[k];
                if (m_cyc[k] < m_max[k]) m_cyc[k]++;
                if (opcode == 4'h8) begin
                    if (m_mac[k] < m_max[k]) m_mac[k]++;
                    m_lm[k] = alu_result;
                end
                if (parity_error) begin
                    if (m_perr[k] == 0) m_fp[k] = pc_value;
                    if (m_perr[k] < m_max[k]) m_perr[k]++;
                end
                if (m_stop[k] && parity_error) m_st[k] = 4;
                else if (pc_value >= 32) begin
                    m_st[k] = 2;
                    m_fr[k] = result_reg;
                end else if (m_pre == 49) m_st[k] = 3;
            end
        end
    end

    task automatic cmp(string tag, int k, logic [2:0] st, logic d, logic t, logic f, logic h,
                       logic [31:0] cyc, logic [31:0] mac, logic [31:0] perr,
                       logic [31:0] lm, logic [31:0] fp, logic [31:0] fr);
        chk({tag, ".state"}, st, m_st[k]);
        chk({tag, ".done"}, d, m_st[k] == 2);
        chk({tag, ".timeout"}, t, m_st[k] == 3);
        chk({tag, ".fault"}, f, m_st[k] == 4);
        chk({tag, ".halt_req"}, h, m_st[k] >= 2);
        chk({tag, ".cycle_count"}, cyc, m_cyc[k]);
        chk({tag, ".mac_count"}, mac, m_mac[k]);
        chk({tag, ".perr_count"}, perr, m_perr[k]);
        chk({tag, ".last_mac"}, lm, m_lm[k]);
        chk({tag, ".first_perr_pc"}, fp, m_fp[k]);
        chk({tag, ".final_result"}, fr, m_fr[k]);
    endtask

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("A", 0, ifA.state, ifA.done, ifA.timeout, ifA.fault, ifA.halt_req, 32'(ifA.cycle_count),
                32'(ifA.mac_count), 32'(ifA.perr_count), ifA.last_mac, ifA.first_perr_pc, ifA.final_result);
            cmp("B", 1, ifB.state, ifB.done, ifB.timeout, ifB.fault, ifB.halt_req, 32'(ifB.cycle_count),
                32'(ifB.mac_count), 32'(ifB.perr_count), ifB.last_mac, ifB.first_perr_pc, ifB.final_result);
            cmp("C", 2, ifC.state, ifC.done, ifC.timeout, ifC.fault, ifC.halt_req, 32'(ifC.cycle_count),
                32'(ifC.mac_count), 32'(ifC.perr_count), ifC.last_mac, ifC.first_perr_pc, ifC.final_result);
        end
    end

    task automatic samp(bit en, logic [31:0] pc, logic [3:0] op, logic [31:0] alu, bit pe, logic [31:0] res);
        run_en = en; pc_value = pc; opcode = op; alu_result = alu; parity_error = pe; result_reg = res;
        @(posedge clk);
        #2;
    endtask

    task automatic do_rst();
        rst = 1'b1;
        samp(0, 0, 0, 0, 0, 0);
        rst = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        #2;
        chk_en = 1'b1;
        chk("reset.state", ifA.state, 0);
        chk("reset.cycle_count", ifA.cycle_count, 0);
        chk("reset.halt_req", ifA.halt_req, 0);
        rst = 1'b0;

        // Reset mid-run, then restart counting from 1.
        samp(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) samp(1, 32'(4 * i), 0, 0, 0, 0);
        chk("t1.cycle7", ifA.cycle_count, 7);
        do_rst();
        chk("t1.rst_state", ifA.state, 0);
        chk("t1.rst_cycle", ifA.cycle_count, 0);
        samp(1, 0, 0, 0, 0, 0);
        samp(1, 0, 0, 0, 0, 0);
        chk("t1.restart_cycle", ifA.cycle_count, 1);

        // Normal run to END_PC with one MAC at PC 28.
        do_rst();
        samp(1, 0, 0, 0, 0, 32'h1E);
        for (int i = 0; i < 9; i++)
            samp(1, 32'(4 * i), (i == 7) ? 4'h8 : 4'h1, (i == 7) ? 32'h1E : 32'(100 + i), 0, 32'h1E);
        chk("t2.done", ifA.done, 1);
        chk("t2.halt_req", ifA.halt_req, 1);
        chk("t2.cycle_count", ifA.cycle_count, 9);
        chk("t2.mac_count", ifA.mac_count, 1);
        chk("t2.last_mac", ifA.last_mac, 32'h1E);
        chk("t2.final_result", ifA.final_result, 32'h1E);
        chk("t2.model_final", m_fr[0], 32'h1E);
        for (int i = 0; i < 3; i++) samp(1, 0, 4'h8, 32'hDEAD, 1, 32'h55);

        // Watchdog with PC held at 8; later inputs ignored.
        do_rst();
        samp(1, 8, 0, 0, 0, 0);
        for (int i = 0; i < 49; i++) samp(1, 8, 0, 0, 0, 0);
        chk("t3.not_yet", ifA.state, 1);
        samp(1, 8, 0, 0, 0, 0);
        chk("t3.timeout", ifA.timeout, 1);
        chk("t3.cycle_count", ifA.cycle_count, 50);
        chk("t3.model_cycle", m_cyc[0], 50);
        chk("t3.C_no_timeout", ifC.state, 1);
        for (int i = 0; i < 4; i++) samp(1, 40, 4'h8, 32'h77, 1, 32'h9);
        chk("t3.frozen_cycle", ifA.cycle_count, 50);

        // Parity errors at PC 12 and 20.
        do_rst();
        samp(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++)
            samp(1, 32'(4 * i), 0, 0, (i == 3) || (i == 5), 32'hABC);
        chk("t4.A_fault", ifA.fault, 1);
        chk("t4.A_perr", ifA.perr_count, 1);
        chk("t4.A_fpc", ifA.first_perr_pc, 12);
        chk("t4.B_done", ifB.done, 1);
        chk("t4.B_perr", ifB.perr_count, 2);
        chk("t4.B_fpc", ifB.first_perr_pc, 12);
        chk("t4.model_B_perr", m_perr[1], 2);

        // Simultaneous: parity with end PC -> FAULT beats DONE.
        do_rst();
        samp(1, 0, 0, 0, 0, 0);
        samp(1, 32, 0, 0, 1, 32'h5);
        chk("t5a.A_fault", ifA.state, 4);
        chk("t5a.B_done", ifB.state, 2);

        // Simultaneous: end PC on sample 50 -> DONE beats TIMEOUT.
        do_rst();
        samp(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 49; i++) samp(1, 8, 0, 0, 0, 0);
        samp(1, 32, 0, 0, 0, 32'h42);
        chk("t5b.A_done", ifA.state, 2);
        chk("t5b.A_cycle", ifA.cycle_count, 50);

        // Pause then saturation of the 4-bit MAC counter.
        do_rst();
        samp(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) samp(1, 8, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) samp(0, 40, 4'h8, 32'hBAD, 1, 0);
        chk("t6.pause_cycle", ifA.cycle_count, 3);
        chk("t6.pause_state", ifA.state, 1);
        chk("t6.pause_mac", ifA.mac_count, 0);
        for (int i = 0; i < 20; i++) samp(1, 8, 4'h8, 32'(i + 1), 0, 0);
        chk("t6.C_mac_sat", ifC.mac_count, 15);
        chk("t6.C_cycle_sat", ifC.cycle_count, 15);
        chk("t6.A_mac", ifA.mac_count, 20);
        chk("t6.A_last_mac", ifA.last_mac, 20);
        chk("t6.model_C_mac", m_mac[2], 15);

        // Randomized traffic, with occasional resets to start new runs.
        do_rst();
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(0, 24) == 0);
            samp($urandom_range(0, 4) != 0, 32'($urandom_range(0, 33)),
                 ($urandom_range(0, 2) == 0) ? 4'h8 : 4'($urandom_range(0, 15)),
                 $urandom, $urandom_range(0, 29) == 0, $urandom);
        end
        rst = 1'b0;
        @(negedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
